bram_sbox_sched: RTL and testbench

BRAM_SBOX_SCHED -- requirements
Module: bram_sbox_sched

---
 rtl/bram_sbox_sched.sv | 176 +++++++++++++++++
 tb/tb_bram_sbox_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sbox_sched.sv
// bram_sbox_sched: issues four masked-byte lookups into a 2-cycle-latency table RAM and packs the results.
// Build option: define SCHED_DUAL_PORT_EN for dual-port issue (2 issue cycles); default is single-port (4 issue cycles).
module bram_sbox_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] share_in,
  input  logic [7:0]  rand_in,
  output logic [9:0]  ADDRA,
  output logic [9:0]  ADDRB,
  output logic        EN,
  input  logic [7:0]  DOA,
  input  logic [7:0]  DOB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

`ifdef SCHED_DUAL_PORT_EN
  localparam logic [1:0] ISSUE_LAST = 2'd1;
`else
  localparam logic [1:0] ISSUE_LAST = 2'd3;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [31:0] share_q;
  logic [7:0]  rand_q;
  logic        accept;
  logic [1:0]  issue_idx, next_idx;
  logic        p1_vld, p2_vld;
  logic [1:0]  p1_idx, p2_idx;
  logic [31:0] result;

  logic        addr_load;
  logic [31:0] src_sh;
  logic [7:0]  src_rn;
  logic [1:0]  src_idx;
  logic [9:0]  addr_a_nxt, addr_b_nxt;

  function automatic logic [9:0] lut_addr(input logic [31:0] sh, input logic [7:0] rn,
                                          input logic [1:0] i);
    lut_addr = {rn[{i, 1'b0} +: 2], sh[{i, 3'b000} +: 8]};
  endfunction

  assign accept    = in_valid && (state == IDLE);
  // cnt counts down through ISSUE, so the slot being driven is its distance from ISSUE_LAST
  assign issue_idx = ISSUE_LAST - cnt;
  assign next_idx  = issue_idx + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    EN        = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = ISSUE;
          cnt_nxt   = ISSUE_LAST;
        end
      end
      ISSUE: begin
        EN = 1'b1;
        if (cnt == 2'd0) begin
          state_nxt = CAPTURE;
          cnt_nxt   = 2'd1;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      CAPTURE: begin
        EN = (cnt == 2'd1);
        if (cnt == 2'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 2'd1;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      share_q <= 32'd0;
      rand_q  <= 8'd0;
    end else if (accept) begin
      share_q <= share_in;
      rand_q  <= rand_in;
    end
  end

  // The first issue slot is addressed straight from the inputs so ADDRA/ADDRB are valid in ISSUE cycle 1
  always_comb begin
    src_sh    = accept ? share_in : share_q;
    src_rn    = accept ? rand_in  : rand_q;
    src_idx   = accept ? 2'd0     : next_idx;
    addr_load = accept || ((state == ISSUE) && (cnt != 2'd0));
`ifdef SCHED_DUAL_PORT_EN
    addr_a_nxt = lut_addr(src_sh, src_rn, {src_idx[0], 1'b0});
    addr_b_nxt = lut_addr(src_sh, src_rn, {src_idx[0], 1'b1});
`else
    addr_a_nxt = lut_addr(src_sh, src_rn, src_idx);
    addr_b_nxt = 10'd0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ADDRA <= 10'd0;
      ADDRB <= 10'd0;
    end else if (addr_load) begin
      ADDRA <= addr_a_nxt;
      ADDRB <= addr_b_nxt;
    end else begin
      ADDRA <= 10'd0;
      ADDRB <= 10'd0;
    end
  end

  // Two-stage slot tracker matching the table read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_vld <= 1'b0;
      p2_vld <= 1'b0;
      p1_idx <= 2'd0;
      p2_idx <= 2'd0;
    end else begin
      p1_vld <= (state == ISSUE);
      p1_idx <= issue_idx;
      p2_vld <= p1_vld;
      p2_idx <= p1_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= 32'd0;
    end else if (p2_vld) begin
`ifdef SCHED_DUAL_PORT_EN
      result[{p2_idx[0], 1'b0, 3'b000} +: 8] <= DOA;
      result[{p2_idx[0], 1'b1, 3'b000} +: 8] <= DOB;
`else
      result[{p2_idx, 3'b000} +: 8] <= DOA;
`endif
    end
  end

  assign out_data = result;

`ifdef SCHED_DUAL_PORT_EN
  logic unused_idx;
  assign unused_idx = p2_idx[1];
`else
  logic unused_dob;
  assign unused_dob = ^DOB;
`endif

endmodule

// File: tb/tb_bram_sbox_sched.sv
// tb_bram_sbox_sched: randomized self-checking bench with a 2-cycle-latency table model.
// Honours SCHED_DUAL_PORT_EN the same way as the design.
module tb_bram_sbox_sched;

`ifdef SCHED_DUAL_PORT_EN
  localparam int N = 2;
  localparam bit DUAL = 1'b1;
`else
  localparam int N = 4;
  localparam bit DUAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] share_in;
  logic [7:0]  rand_in;
  logic [9:0]  ADDRA;
  logic [9:0]  ADDRB;
  logic        EN;
  logic [7:0]  DOA;
  logic [7:0]  DOB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  tbl [0:1023];
  logic [7:0]  a_s1, b_s1;

  logic [9:0]  obs_a [0:20];
  logic [9:0]  obs_b [0:20];
  int          obs_lat;
  int          obs_en;
  logic [31:0] obs_data;

  bram_sbox_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .share_in(share_in), .rand_in(rand_in), .ADDRA(ADDRA), .ADDRB(ADDRB),
    .EN(EN), .DOA(DOA), .DOB(DOB), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Table model: registered read plus enabled output register, reset by the same rst
  always @(posedge clk) begin
    if (rst) begin
      a_s1 <= 8'd0; b_s1 <= 8'd0; DOA <= 8'd0; DOB <= 8'd0;
    end else if (EN) begin
      a_s1 <= tbl[ADDRA]; b_s1 <= tbl[ADDRB];
      DOA  <= a_s1;       DOB  <= b_s1;
    end
  end

  function automatic logic [9:0] m_addr(input logic [31:0] sh, input logic [7:0] rn, input int b);
    m_addr = {rn[2*b +: 2], sh[8*b +: 8]};
  endfunction

  function automatic logic [9:0] exp_a(input logic [31:0] sh, input logic [7:0] rn, input int c);
    if (c < 1 || c > N) exp_a = 10'd0;
    else if (DUAL)      exp_a = m_addr(sh, rn, 2*(c-1));
    else                exp_a = m_addr(sh, rn, c-1);
  endfunction

  function automatic logic [9:0] exp_b(input logic [31:0] sh, input logic [7:0] rn, input int c);
    if (c < 1 || c > N || !DUAL) exp_b = 10'd0;
    else                         exp_b = m_addr(sh, rn, 2*c-1);
  endfunction

  function automatic logic [31:0] m_data(input logic [31:0] sh, input logic [7:0] rn);
    logic [31:0] r;
    r = 32'd0;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = tbl[m_addr(sh, rn, b)];
    m_data = r;
  endfunction

  // Drives one word from a negedge and records outputs per cycle until out_valid (out_ready held low)
  task automatic do_word(input logic [31:0] sh, input logic [7:0] rn);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL idle_wait: in_ready=%0b, required 1 within 20 cycles", in_ready);
    end
    in_valid = 1'b1; share_in = sh; rand_in = rn; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; share_in = $urandom; rand_in = 8'($urandom);
    obs_lat = 0; obs_en = 0; obs_data = 32'd0;
    for (int c = 1; c <= 20; c++) begin
      obs_a[c] = ADDRA; obs_b[c] = ADDRB;
      if (EN) obs_en++;
      if (out_valid) begin obs_lat = c; obs_data = out_data; break; end
      @(negedge clk);
    end
  endtask

  task automatic finish_word();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; share_in = 32'd0; rand_in = 8'd0;
    repeat (3) @(negedge clk);
    n_tests++; if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    n_tests++; if (EN !== 1'b0)           begin n_fail++; $display("FAIL rst_en: got %0b want 0", EN); end
    n_tests++; if (ADDRA !== 10'd0)       begin n_fail++; $display("FAIL rst_addra: got %h want 000", ADDRA); end
    n_tests++; if (ADDRB !== 10'd0)       begin n_fail++; $display("FAIL rst_addrb: got %h want 000", ADDRB); end
    n_tests++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_tests++; if (out_data !== 32'd0)    begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [9:0] ea, eb;
    do_word(32'h0F0E0D0C, 8'h00);
    for (int c = 1; c <= obs_lat; c++) begin
      if (c > N)     begin ea = 10'd0; eb = 10'd0; end
      else if (DUAL) begin ea = 10'(10 + 2*c); eb = 10'(11 + 2*c); end
      else           begin ea = 10'(11 + c);   eb = 10'd0; end
      n_tests++; if (obs_a[c] !== ea) begin n_fail++; $display("FAIL dir_addra c%0d: got %h want %h", c, obs_a[c], ea); end
      n_tests++; if (obs_b[c] !== eb) begin n_fail++; $display("FAIL dir_addrb c%0d: got %h want %h", c, obs_b[c], eb); end
    end
    n_tests++; if (obs_lat !== N+3)          begin n_fail++; $display("FAIL dir_latency: got %0d want %0d", obs_lat, N+3); end
    n_tests++; if (obs_en !== N+1)           begin n_fail++; $display("FAIL dir_en_cycles: got %0d want %0d", obs_en, N+1); end
    n_tests++; if (obs_data !== 32'h01E404E1) begin n_fail++; $display("FAIL dir_data: got %h want 01e404e1", obs_data); end
    finish_word();
  endtask

  task automatic test_selector();
    logic [9:0] ea, eb;
    do_word(32'h00000000, 8'hE4);
    for (int c = 1; c <= N; c++) begin
      if (DUAL) begin ea = 10'((2*(c-1)) << 8); eb = 10'((2*c-1) << 8); end
      else      begin ea = 10'((c-1) << 8);     eb = 10'd0; end
      n_tests++; if (obs_a[c] !== ea) begin n_fail++; $display("FAIL sel_addra c%0d: got %h want %h", c, obs_a[c], ea); end
      n_tests++; if (obs_b[c] !== eb) begin n_fail++; $display("FAIL sel_addrb c%0d: got %h want %h", c, obs_b[c], eb); end
    end
    n_tests++;
    if (obs_data !== {tbl[10'h300], tbl[10'h200], tbl[10'h100], tbl[10'h000]}) begin
      n_fail++; $display("FAIL sel_data: got %h want %h", obs_data, {tbl[10'h300], tbl[10'h200], tbl[10'h100], tbl[10'h000]});
    end
    finish_word();
  endtask

  task automatic test_random();
    logic [31:0] sh;
    logic [7:0]  rn;
    for (int k = 0; k < 12; k++) begin
      sh = $urandom; rn = 8'($urandom);
      do_word(sh, rn);
      for (int c = 1; c <= obs_lat; c++) begin
        n_tests++; if (obs_a[c] !== exp_a(sh, rn, c)) begin n_fail++; $display("FAIL rnd_addra w%0d c%0d: got %h want %h", k, c, obs_a[c], exp_a(sh, rn, c)); end
        n_tests++; if (obs_b[c] !== exp_b(sh, rn, c)) begin n_fail++; $display("FAIL rnd_addrb w%0d c%0d: got %h want %h", k, c, obs_b[c], exp_b(sh, rn, c)); end
      end
      n_tests++; if (obs_lat !== N+3) begin n_fail++; $display("FAIL rnd_latency w%0d: got %0d want %0d", k, obs_lat, N+3); end
      n_tests++; if (obs_en !== N+1)  begin n_fail++; $display("FAIL rnd_en_cycles w%0d: got %0d want %0d", k, obs_en, N+1); end
      n_tests++; if (obs_data !== m_data(sh, rn)) begin n_fail++; $display("FAIL rnd_data w%0d: got %h want %h", k, obs_data, m_data(sh, rn)); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      finish_word();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] sh, exp;
    logic [7:0]  rn;
    int bad;
    sh = $urandom; rn = 8'($urandom);
    exp = m_data(sh, rn);
    do_word(sh, rn);
    for (int k = 0; k < 6; k++) begin
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid k%0d: got %0b want 1", k, out_valid); end
      n_tests++; if (out_data !== exp)   begin n_fail++; $display("FAIL bp_out_data k%0d: got %h want %h", k, out_data, exp); end
      n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_in_ready k%0d: got %0b want 0", k, in_ready); end
      in_valid = 1'($urandom); share_in = $urandom; rand_in = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_tests++; if (out_data !== exp) begin n_fail++; $display("FAIL bp_data_before_xfer: got %h want %h", out_data, exp); end
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_in_ready_after: got %0b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_out_valid_after: got %0b want 0", out_valid); end
    bad = 0;
    repeat (8) begin @(negedge clk); if (EN || out_valid || !in_ready) bad++; end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bp_idle_after: got %0d busy cycles want 0", bad); end
  endtask

  task automatic test_reset_mid();
    int vcnt, ecnt;
    in_valid = 1'b1; share_in = $urandom; rand_in = 8'($urandom); out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rmid_in_ready: got %0b want 1", in_ready); end
    n_tests++; if (EN !== 1'b0)        begin n_fail++; $display("FAIL rmid_en: got %0b want 0", EN); end
    n_tests++; if (ADDRA !== 10'd0)    begin n_fail++; $display("FAIL rmid_addra: got %h want 000", ADDRA); end
    n_tests++; if (ADDRB !== 10'd0)    begin n_fail++; $display("FAIL rmid_addrb: got %h want 000", ADDRB); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %0b want 0", out_valid); end
    n_tests++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL rmid_out_data: got %h want 0", out_data); end
    rst = 1'b0;
    vcnt = 0; ecnt = 0;
    repeat (15) begin @(negedge clk); if (out_valid) vcnt++; if (EN) ecnt++; end
    n_tests++; if (vcnt !== 0) begin n_fail++; $display("FAIL rmid_no_output: got %0d valid cycles want 0", vcnt); end
    n_tests++; if (ecnt !== 0) begin n_fail++; $display("FAIL rmid_no_en: got %0d en cycles want 0", ecnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] expq[$];
    logic [31:0] e;
    int last, en_since, n_acc;
    last = -1; en_since = 0; n_acc = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc == 66) in_valid = 1'b0;
      share_in = $urandom; rand_in = 8'($urandom);
      if (EN) en_since++;
      if (out_valid) begin
        if (expq.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL b2b_extra_output: got %h want none", out_data);
        end else begin
          e = expq.pop_front();
          n_tests++; if (out_data !== e) begin n_fail++; $display("FAIL b2b_data: got %h want %h", out_data, e); end
        end
      end
      if (in_ready && in_valid) begin
        if (last >= 0) begin
          n_tests++; if (cyc - last !== N+4) begin n_fail++; $display("FAIL b2b_interval: got %0d want %0d", cyc - last, N+4); end
          n_tests++; if (en_since !== N+1)   begin n_fail++; $display("FAIL b2b_en_cycles: got %0d want %0d", en_since, N+1); end
        end
        expq.push_back(m_data(share_in, rand_in));
        last = cyc; en_since = 0; n_acc++;
      end
      @(negedge clk);
    end
    n_tests++; if (n_acc < 66 / (N+4)) begin n_fail++; $display("FAIL b2b_accepts: got %0d want >= %0d", n_acc, 66 / (N+4)); end
    n_tests++; if (expq.size() !== 0)  begin n_fail++; $display("FAIL b2b_drain: got %0d pending want 0", expq.size()); end
    out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) tbl[i] = 8'((i * 73 + 41) ^ (i >> 2));
    tbl[10'h00C] = 8'hE1; tbl[10'h00D] = 8'h04; tbl[10'h00E] = 8'hE4; tbl[10'h00F] = 8'h01;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; share_in = 32'd0; rand_in = 8'd0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_selector();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
